// File: rtl/run_monitor_pkg.sv
// Shared types for run_monitor: result codes, FSM state encoding and the
// per-cycle verdict that ends a run.
package run_monitor_pkg;

  localparam int RESULT_W = 3;
  localparam int CH_ID_W  = 4;
  localparam int MAX_CH   = 16;

  typedef enum logic [RESULT_W-1:0] {
    RES_NONE    = 3'd0,
    RES_BREAK   = 3'd1,
    RES_FAULT   = 3'd2,
    RES_TIMEOUT = 3'd3,
    RES_STALL   = 3'd4
  } result_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Outcome of one RUN cycle: whether the run ends, why, and which channel.
  typedef struct packed {
    logic                 hit;
    result_e              result;
    logic [CH_ID_W-1:0]   ch_id;
  } verdict_t;

endpackage

// File: rtl/run_monitor_prio_enc.sv
// Lowest-set-index encoder with an any-bit flag; index is 0 when nothing is set.
module run_monitor_prio_enc
  import run_monitor_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]   req_i,
  output logic [CH_ID_W-1:0] idx_o,
  output logic               any_o
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    idx_o = '0;
    any_o = |req_i;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = CH_ID_W'(i);
    end
  end

endmodule

// File: rtl/run_monitor.sv
// Run monitor: tracks one CPU run across NUM_CH channels and reports how it ended.
// Optional per-channel stall detection is built when RUN_MONITOR_STALL_EN is defined.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int NUM_CH         = 1,
  parameter int CYCLE_W        = 32,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int BREAK_ALL      = 0,
  parameter int STALL_CYCLES   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [NUM_CH-1:0]   fault_i,
  input  logic [NUM_CH-1:0]   break_i,
  input  logic [NUM_CH-1:0]   activity_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                done_pulse_o,
  output logic [RESULT_W-1:0] result_o,
  output logic [CH_ID_W-1:0]  ch_id_o,
  output logic [CYCLE_W-1:0]  cycles_o,
  output logic [NUM_CH-1:0]   break_mask_o
);

  localparam bit               TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CYCLE_W-1:0] TIMEOUT_LIMIT = CYCLE_W'(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  logic [CYCLE_W-1:0]  cycles_q, cycles_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  result_e             result_q, result_d;
  logic [CH_ID_W-1:0]  ch_id_q, ch_id_d;
  logic                pulse_q, pulse_d;

  logic                run_start;
  logic                in_run;
  logic [CYCLE_W-1:0]  cyc_inc;
  logic                timeout_hit;
  verdict_t            verdict;

  assign in_run  = (state_q == ST_RUN);
  assign cyc_inc = (cycles_q == '1) ? cycles_q : cycles_q + CYCLE_W'(1);
  assign timeout_hit = TIMEOUT_EN && (cyc_inc == TIMEOUT_LIMIT);

  // ---------------------------------------------------------------------------
  // Event selection
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]  brk_cand;
  logic               brk_done;
  logic [NUM_CH-1:0]  stall_vec;

  logic [CH_ID_W-1:0] fault_idx, brk_idx, stall_idx;
  logic               fault_any, brk_any, stall_any;

  generate
    if (BREAK_ALL != 0) begin : g_break_all
      // Complete once every channel has broken; report the channel that closed the set.
      assign brk_cand = break_i & ~mask_q;
      assign brk_done = &(mask_q | break_i);
    end else begin : g_break_any
      assign brk_cand = break_i;
      assign brk_done = |break_i;
    end
  endgenerate

  run_monitor_prio_enc #(.WIDTH(NUM_CH)) u_fault_enc (
    .req_i (fault_i),
    .idx_o (fault_idx),
    .any_o (fault_any)
  );

  run_monitor_prio_enc #(.WIDTH(NUM_CH)) u_break_enc (
    .req_i (brk_cand),
    .idx_o (brk_idx),
    .any_o (brk_any)
  );

  run_monitor_prio_enc #(.WIDTH(NUM_CH)) u_stall_enc (
    .req_i (stall_vec),
    .idx_o (stall_idx),
    .any_o (stall_any)
  );

`ifdef RUN_MONITOR_STALL_EN
  localparam int IDLE_W = (STALL_CYCLES < 1) ? 1 : $clog2(STALL_CYCLES + 1);
  localparam logic [IDLE_W-1:0] STALL_LIMIT = IDLE_W'(STALL_CYCLES);

  logic [NUM_CH-1:0][IDLE_W-1:0] idle_q, idle_d, idle_inc;

  always_comb begin
    idle_inc  = '0;
    stall_vec = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!activity_i[c]) begin
        idle_inc[c] = (idle_q[c] == '1) ? idle_q[c] : idle_q[c] + IDLE_W'(1);
      end
      stall_vec[c] = (idle_inc[c] >= STALL_LIMIT);
    end
  end

  always_comb begin
    idle_d = idle_q;
    if (run_start)   idle_d = '0;
    else if (in_run) idle_d = idle_inc;
  end

  always_ff @(posedge clk) begin
    // NOTE: the idle counters are state like any other and are cleared by
    // reset explicitly; nothing here relies on power-up values.
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_activity;
  assign unused_activity = ^activity_i;
  assign stall_vec       = '0;
`endif

  // Priority: fault > break completion > stall > timeout.
  always_comb begin
    verdict = '{hit: 1'b0, result: RES_NONE, ch_id: '0};
    if (fault_any) begin
      verdict = '{hit: 1'b1, result: RES_FAULT, ch_id: fault_idx};
    end else if (brk_done) begin
      verdict = '{hit: 1'b1, result: RES_BREAK,
                  ch_id: brk_any ? brk_idx : '0};
    end else if (stall_any) begin
      verdict = '{hit: 1'b1, result: RES_STALL, ch_id: stall_idx};
    end else if (timeout_hit) begin
      verdict = '{hit: 1'b1, result: RES_TIMEOUT, ch_id: '0};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cycles_d  = cycles_q;
    mask_d    = mask_q;
    result_d  = result_q;
    ch_id_d   = ch_id_q;
    pulse_d   = 1'b0;
    run_start = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          run_start = 1'b1;
          state_d   = ST_RUN;
          cycles_d  = '0;
          mask_d    = '0;
          result_d  = RES_NONE;
          ch_id_d   = '0;
        end
      end
      ST_RUN: begin
        cycles_d = cyc_inc;
        mask_d   = mask_q | break_i;
        if (verdict.hit) begin
          state_d  = ST_DONE;
          result_d = verdict.result;
          ch_id_d  = verdict.ch_id;
          pulse_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      cycles_q <= '0;
      mask_q   <= '0;
      result_q <= RES_NONE;
      ch_id_q  <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      ch_id_q  <= ch_id_d;
      pulse_q  <= pulse_d;
    end
  end

  assign busy_o       = in_run;
  assign done_o       = (state_q == ST_DONE);
  assign done_pulse_o = pulse_q;
  assign result_o     = result_q;
  assign ch_id_o      = ch_id_q;
  assign cycles_o     = cycles_q;
  assign break_mask_o = mask_q;

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: several parameterisations side by side, each
// driven with hand-computed vectors. Stall expectations follow RUN_MONITOR_STALL_EN.
module tb_run_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // A: NUM_CH=1, defaults
  logic a_start = 0; logic [0:0] a_fault = '0, a_brk = '0, a_act = '0;
  logic a_busy, a_done, a_pulse; logic [2:0] a_result; logic [3:0] a_ch;
  logic [31:0] a_cycles; logic [0:0] a_mask;
  // B: NUM_CH=4, TIMEOUT_CYCLES=10
  logic b_start = 0; logic [3:0] b_fault = '0, b_brk = '0, b_act = '0;
  logic b_busy, b_done, b_pulse; logic [2:0] b_result; logic [3:0] b_ch;
  logic [31:0] b_cycles; logic [3:0] b_mask;
  // C: NUM_CH=1, timeout disabled
  logic c_start = 0; logic [0:0] c_fault = '0, c_brk = '0, c_act = '0;
  logic c_busy, c_done, c_pulse; logic [2:0] c_result; logic [3:0] c_ch;
  logic [31:0] c_cycles; logic [0:0] c_mask;
  // D: NUM_CH=3, BREAK_ALL=1
  logic d_start = 0; logic [2:0] d_fault = '0, d_brk = '0, d_act = '0;
  logic d_busy, d_done, d_pulse; logic [2:0] d_result; logic [3:0] d_ch;
  logic [31:0] d_cycles; logic [2:0] d_mask;
  // E: NUM_CH=2, STALL_CYCLES=8, TIMEOUT_CYCLES=100
  logic e_start = 0; logic [1:0] e_fault = '0, e_brk = '0, e_act = '0;
  logic e_busy, e_done, e_pulse; logic [2:0] e_result; logic [3:0] e_ch;
  logic [31:0] e_cycles; logic [1:0] e_mask;

  run_monitor #(.NUM_CH(1)) u_a (
    .clk(clk), .rst(rst), .start_i(a_start), .fault_i(a_fault), .break_i(a_brk),
    .activity_i(a_act), .busy_o(a_busy), .done_o(a_done), .done_pulse_o(a_pulse),
    .result_o(a_result), .ch_id_o(a_ch), .cycles_o(a_cycles), .break_mask_o(a_mask));

  run_monitor #(.NUM_CH(4), .TIMEOUT_CYCLES(10)) u_b (
    .clk(clk), .rst(rst), .start_i(b_start), .fault_i(b_fault), .break_i(b_brk),
    .activity_i(b_act), .busy_o(b_busy), .done_o(b_done), .done_pulse_o(b_pulse),
    .result_o(b_result), .ch_id_o(b_ch), .cycles_o(b_cycles), .break_mask_o(b_mask));

  run_monitor #(.NUM_CH(1), .TIMEOUT_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .start_i(c_start), .fault_i(c_fault), .break_i(c_brk),
    .activity_i(c_act), .busy_o(c_busy), .done_o(c_done), .done_pulse_o(c_pulse),
    .result_o(c_result), .ch_id_o(c_ch), .cycles_o(c_cycles), .break_mask_o(c_mask));

  run_monitor #(.NUM_CH(3), .BREAK_ALL(1)) u_d (
    .clk(clk), .rst(rst), .start_i(d_start), .fault_i(d_fault), .break_i(d_brk),
    .activity_i(d_act), .busy_o(d_busy), .done_o(d_done), .done_pulse_o(d_pulse),
    .result_o(d_result), .ch_id_o(d_ch), .cycles_o(d_cycles), .break_mask_o(d_mask));

  run_monitor #(.NUM_CH(2), .STALL_CYCLES(8), .TIMEOUT_CYCLES(100)) u_e (
    .clk(clk), .rst(rst), .start_i(e_start), .fault_i(e_fault), .break_i(e_brk),
    .activity_i(e_act), .busy_o(e_busy), .done_o(e_done), .done_pulse_o(e_pulse),
    .result_o(e_result), .ch_id_o(e_ch), .cycles_o(e_cycles), .break_mask_o(e_mask));

  int a_pulse_cnt = 0;
  always @(negedge clk) if (a_pulse) a_pulse_cnt <= a_pulse_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Inputs change and outputs are sampled on the falling edge.
  initial begin
    repeat (2) @(negedge clk);
    check("rst_a", 32'({a_busy, a_done, a_pulse, a_result, a_ch, a_mask}), 0);
    check("rst_a_cyc", a_cycles, 0);
    check("rst_b", 32'({b_busy, b_done, b_pulse, b_result, b_ch, b_mask}), 0);
    check("rst_c", 32'({c_busy, c_done, c_pulse, c_result, c_ch, c_mask}), 0);
    check("rst_d", 32'({d_busy, d_done, d_pulse, d_result, d_ch, d_mask}), 0);
    check("rst_e", 32'({e_busy, e_done, e_pulse, e_result, e_ch, e_mask}), 0);
    check("rst_cyc_bcde", b_cycles | c_cycles | d_cycles | e_cycles, 0);
    rst = 1'b0;

    // ---- A: single channel, break on RUN cycle 7 ----
    a_start = 1; @(negedge clk); a_start = 0;
    check("a_busy", 32'(a_busy), 1);
    check("a_cyc0", a_cycles, 0);
    repeat (6) @(negedge clk);
    check("a_cyc_live", a_cycles, 6);
    a_brk = 1; @(negedge clk); a_brk = 0;
    check("a_done", 32'({a_busy, a_done, a_pulse}), 32'b011);
    check("a_result", 32'(a_result), 1);
    check("a_cycles", a_cycles, 7);
    check("a_ch", 32'(a_ch), 0);
    check("a_mask", 32'(a_mask), 1);
    repeat (3) @(negedge clk);
    check("a_pulse_low", 32'({a_done, a_pulse}), 32'b10);
    check("a_pulse_cnt", a_pulse_cnt, 1);
    check("a_hold_cyc", a_cycles, 7);

    // ---- A: reset mid-run at cycle 20, then a fresh run ----
    a_start = 1; @(negedge clk); a_start = 0;
    repeat (19) @(negedge clk);
    check("a_cyc19", a_cycles, 19);
    rst = 1; a_start = 1; @(negedge clk);
    check("a_rst_mid", 32'({a_busy, a_done, a_pulse, a_result, a_ch, a_mask}), 0);
    check("a_rst_cyc", a_cycles, 0);
    rst = 0; @(negedge clk); a_start = 0;
    check("a_restart_busy", 32'(a_busy), 1);
    check("a_restart_cyc0", a_cycles, 0);
    @(negedge clk);
    check("a_restart_cyc1", a_cycles, 1);

    // ---- B: fault beats break on the same cycle ----
    b_start = 1; @(negedge clk); b_start = 0;
    repeat (2) @(negedge clk);
    b_fault = 4'b1010; b_brk = 4'b0001; @(negedge clk);
    b_fault = '0; b_brk = '0;
    check("b_fault_res", 32'(b_result), 2);
    check("b_fault_ch", 32'(b_ch), 1);
    check("b_fault_cyc", b_cycles, 3);
    check("b_fault_mask", 32'(b_mask), 32'b0001);
    check("b_fault_done", 32'({b_busy, b_done, b_pulse}), 32'b011);
    b_fault = 4'b1111; b_brk = 4'b1111; repeat (2) @(negedge clk);
    b_fault = '0; b_brk = '0;
    check("b_hold", 32'({b_done, b_pulse, b_result, b_ch, b_mask}), 32'({2'b10, 3'd2, 4'd1, 4'b0001}));
    check("b_hold_cyc", b_cycles, 3);

    // ---- B: timeout at 11 with a start pulse ignored mid-run ----
    b_start = 1; @(negedge clk); b_start = 0;
    check("b_restart", 32'({b_busy, b_done, b_result, b_ch, b_mask}), 32'({2'b10, 3'd0, 4'd0, 4'b0}));
    check("b_restart_cyc", b_cycles, 0);
    repeat (3) @(negedge clk);
    b_start = 1; @(negedge clk); b_start = 0;
    repeat (6) @(negedge clk);
    check("b_to_pre", 32'({b_busy, b_done}), 32'b10);
    check("b_to_pre_cyc", b_cycles, 10);
    @(negedge clk);
    check("b_to_res", 32'({b_done, b_result, b_ch}), 32'({1'b1, 3'd3, 4'd0}));
    check("b_to_cyc", b_cycles, 11);

    // ---- B: break on first cycle, lowest of several ----
    b_start = 1; @(negedge clk); b_start = 0;
    b_brk = 4'b1100; @(negedge clk); b_brk = '0;
    check("b_brk_res", 32'({b_done, b_result, b_ch}), 32'({1'b1, 3'd1, 4'd2}));
    check("b_brk_cyc", b_cycles, 1);

    // ---- C: timeout disabled ----
    c_start = 1; @(negedge clk); c_start = 0;
    repeat (1000) @(negedge clk);
    check("c_busy", 32'({c_busy, c_done, c_result}), 32'({2'b10, 3'd0}));
    check("c_cyc", c_cycles, 1000);

    // ---- D: all-channel break completion ----
    d_start = 1; @(negedge clk); d_start = 0;
    @(negedge clk);
    d_brk = 3'b001; @(negedge clk); d_brk = '0;
    check("d_mask2", 32'({d_busy, d_mask}), 32'({1'b1, 3'b001}));
    check("d_cyc2", d_cycles, 2);
    repeat (2) @(negedge clk);
    d_brk = 3'b100; @(negedge clk); d_brk = '0;
    check("d_mask5", 32'({d_busy, d_mask}), 32'({1'b1, 3'b101}));
    repeat (3) @(negedge clk);
    d_brk = 3'b011; @(negedge clk); d_brk = '0;
    check("d_done", 32'({d_done, d_pulse, d_result, d_ch}), 32'({2'b11, 3'd1, 4'd1}));
    check("d_mask", 32'(d_mask), 32'b111);
    check("d_cyc", d_cycles, 9);

    // ---- E: ch0 always active, ch1 never ----
    e_act = 2'b01;
    e_start = 1; @(negedge clk); e_start = 0;
    repeat (7) @(negedge clk);
    check("e_busy7", 32'(e_busy), 1);
    @(negedge clk);
`ifdef RUN_MONITOR_STALL_EN
    check("e_stall", 32'({e_done, e_result, e_ch}), 32'({1'b1, 3'd4, 4'd1}));
    check("e_stall_cyc", e_cycles, 8);
`else
    check("e_nostall", 32'({e_busy, e_result}), 32'({1'b1, 3'd0}));
    check("e_nostall_cyc", e_cycles, 8);
    repeat (93) @(negedge clk);
    check("e_timeout", 32'({e_done, e_result, e_ch}), 32'({1'b1, 3'd3, 4'd0}));
    check("e_timeout_cyc", e_cycles, 101);
`endif
    e_act = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
